// File: rtl/regfile_pkg.sv
// regfile_pkg: destination code map shared by the bus source mux and the destination register file
package regfile_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG = 24;
  localparam logic [4:0] DEST_R0 = 5'd0, DEST_R1 = 5'd1, DEST_R2 = 5'd2, DEST_R3 = 5'd3;
  localparam logic [4:0] DEST_R4 = 5'd4, DEST_R5 = 5'd5, DEST_R6 = 5'd6, DEST_R7 = 5'd7;
  localparam logic [4:0] DEST_R8 = 5'd8, DEST_R9 = 5'd9, DEST_R10 = 5'd10, DEST_R11 = 5'd11;
  localparam logic [4:0] DEST_R12 = 5'd12, DEST_R13 = 5'd13, DEST_R14 = 5'd14, DEST_R15 = 5'd15;
  localparam logic [4:0] DEST_HI = 5'd16, DEST_LO = 5'd17, DEST_ZHI = 5'd18, DEST_ZLO = 5'd19;
  localparam logic [4:0] DEST_PC = 5'd20, DEST_MDR = 5'd21, DEST_OUTPORT = 5'd22, DEST_MAR = 5'd23;
  localparam logic [4:0] DEST_LAST_LEGAL = 5'd23;
endpackage

// File: rtl/bus_reg.sv
// bus_reg: bus-width register with synchronous clear to RST and load enable
module bus_reg #(
  parameter int unsigned W = 32,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= RST;
    else if (ld) q <= d;
endmodule

// File: rtl/bus_dest_regfile.sv
// bus_dest_regfile: captures the bus into R0-R15/HI/LO/Z/PC/MDR/Out_Port/MAR by destination code; REGFILE_R0_ZERO_EN hardwires R0 to zero
module bus_dest_regfile import regfile_pkg::*; #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter logic [DATA_W-1:0] PC_STEP = DATA_W'(1),
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [DATA_W-1:0]    bus_in,
  input  logic [4:0]           dest_sel,
  input  logic                 wr_en,
  input  logic                 pc_inc,
  input  logic                 z_load,
  input  logic [2*DATA_W-1:0]  alu_result,
  input  logic                 mdr_read,
  input  logic [DATA_W-1:0]    mem_data,
  output logic [16*DATA_W-1:0] gpr_flat,
  output logic [DATA_W-1:0]    hi_q,
  output logic [DATA_W-1:0]    lo_q,
  output logic [DATA_W-1:0]    zhi_q,
  output logic [DATA_W-1:0]    zlo_q,
  output logic [DATA_W-1:0]    pc_q,
  output logic [DATA_W-1:0]    mdr_q,
  output logic [DATA_W-1:0]    outport_q,
  output logic [DATA_W-1:0]    mar_q,
  output logic                 bad_sel
);
`ifdef REGFILE_R0_ZERO_EN
  localparam logic [NREG-1:0] WR_MASK = ~NREG'(1);
`else
  localparam logic [NREG-1:0] WR_MASK = '1;
`endif
  logic [NREG-1:0] ld;
  logic [DATA_W-1:0] pc_d, zhi_d, zlo_d, mdr_d;
  always_comb begin
    ld = wr_en ? (NREG'(1) << dest_sel) & WR_MASK : '0;
    pc_d = ld[DEST_PC] ? bus_in : pc_q + PC_STEP;
    zhi_d = z_load ? alu_result[2*DATA_W-1:DATA_W] : bus_in;
    zlo_d = z_load ? alu_result[DATA_W-1:0] : bus_in;
    mdr_d = mdr_read ? mem_data : bus_in;
  end
  for (genvar g = 0; g < 16; g++) begin : gpr
    bus_reg #(.W(DATA_W)) u_r (.clk(clk), .clr(clr), .ld(ld[g]), .d(bus_in), .q(gpr_flat[g*DATA_W +: DATA_W]));
  end
  bus_reg #(.W(DATA_W)) u_hi (.clk(clk), .clr(clr), .ld(ld[DEST_HI]), .d(bus_in), .q(hi_q));
  bus_reg #(.W(DATA_W)) u_lo (.clk(clk), .clr(clr), .ld(ld[DEST_LO]), .d(bus_in), .q(lo_q));
  bus_reg #(.W(DATA_W)) u_zhi (.clk(clk), .clr(clr), .ld(z_load | ld[DEST_ZHI]), .d(zhi_d), .q(zhi_q));
  bus_reg #(.W(DATA_W)) u_zlo (.clk(clk), .clr(clr), .ld(z_load | ld[DEST_ZLO]), .d(zlo_d), .q(zlo_q));
  bus_reg #(.W(DATA_W), .RST(PC_RESET)) u_pc (.clk(clk), .clr(clr), .ld(pc_inc | ld[DEST_PC]), .d(pc_d), .q(pc_q));
  bus_reg #(.W(DATA_W)) u_mdr (.clk(clk), .clr(clr), .ld(mdr_read | ld[DEST_MDR]), .d(mdr_d), .q(mdr_q));
  bus_reg #(.W(DATA_W)) u_out (.clk(clk), .clr(clr), .ld(ld[DEST_OUTPORT]), .d(bus_in), .q(outport_q));
  bus_reg #(.W(DATA_W)) u_mar (.clk(clk), .clr(clr), .ld(ld[DEST_MAR]), .d(bus_in), .q(mar_q));
  always_ff @(posedge clk)
    if (clr) bad_sel <= 1'b0;
    else if (wr_en && dest_sel > DEST_LAST_LEGAL) bad_sel <= 1'b1;
endmodule

// File: tb/tb_bus_dest_regfile.sv
// tb_bus_dest_regfile: directed vectors checked against a code-indexed register model every cycle plus literal expectations
module tb_bus_dest_regfile;
  logic clk = 0, clr = 1, wr_en = 0, pc_inc = 0, z_load = 0, mdr_read = 0;
  logic [31:0] bus_in = 0, mem_data = 0;
  logic [4:0] dest_sel = 0;
  logic [63:0] alu_result = 0;
  logic [511:0] gpr_flat;
  logic [31:0] hi_q, lo_q, zhi_q, zlo_q, pc_q, mdr_q, outport_q, mar_q;
  logic bad_sel;
  logic [31:0] m [24];
  logic m_bad;
  logic started = 0;
  int checks = 0, errors = 0;
  bus_dest_regfile dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .dest_sel(dest_sel), .wr_en(wr_en),
    .pc_inc(pc_inc), .z_load(z_load), .alu_result(alu_result), .mdr_read(mdr_read),
    .mem_data(mem_data), .gpr_flat(gpr_flat), .hi_q(hi_q), .lo_q(lo_q), .zhi_q(zhi_q),
    .zlo_q(zlo_q), .pc_q(pc_q), .mdr_q(mdr_q), .outport_q(outport_q), .mar_q(mar_q),
    .bad_sel(bad_sel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at %0t", name, idx, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    logic [31:0] n [24];
    n = m;
    if (clr) begin
      for (int i = 0; i < 24; i++) n[i] = 32'd0;
      m_bad <= 1'b0;
    end else begin
      if (wr_en && dest_sel >= 5'd24) m_bad <= 1'b1;
`ifdef REGFILE_R0_ZERO_EN
      if (wr_en && dest_sel < 5'd24 && dest_sel != 5'd0) n[dest_sel] = bus_in;
`else
      if (wr_en && dest_sel < 5'd24) n[dest_sel] = bus_in;
`endif
      if (pc_inc && !(wr_en && dest_sel == 5'd20)) n[20] = m[20] + 32'd1;
      if (z_load) begin
        n[18] = alu_result[63:32];
        n[19] = alu_result[31:0];
      end
      if (mdr_read) n[21] = mem_data;
    end
    m <= n;
  end
  always @(negedge clk) if (started) begin
    for (int i = 0; i < 16; i++) chk("gpr", i, gpr_flat[i*32 +: 32], m[i]);
    chk("hi", 0, hi_q, m[16]);
    chk("lo", 0, lo_q, m[17]);
    chk("zhi", 0, zhi_q, m[18]);
    chk("zlo", 0, zlo_q, m[19]);
    chk("pc", 0, pc_q, m[20]);
    chk("mdr", 0, mdr_q, m[21]);
    chk("outport", 0, outport_q, m[22]);
    chk("mar", 0, mar_q, m[23]);
    chk("bad_sel", 0, {31'd0, bad_sel}, {31'd0, m_bad});
  end
  task automatic step(input logic c, input logic w, input logic [4:0] s, input logic [31:0] b,
                      input logic inc, input logic zl, input logic [63:0] a,
                      input logic mr, input logic [31:0] md);
    @(negedge clk);
    clr = c; wr_en = w; dest_sel = s; bus_in = b; pc_inc = inc;
    z_load = zl; alu_result = a; mdr_read = mr; mem_data = md;
    @(posedge clk);
    #1;
    clr = 0; wr_en = 0; pc_inc = 0; z_load = 0; mdr_read = 0;
  endtask
  task automatic wr(input logic [4:0] s, input logic [31:0] b);
    step(0, 1, s, b, 0, 0, 64'd0, 0, 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    clr = 0;
    started = 1;
    wr(5'd5, 32'hDEADBEEF);
    chk("lit_r5", 5, gpr_flat[5*32 +: 32], 32'hDEADBEEF);
    chk("lit_r4", 4, gpr_flat[4*32 +: 32], 32'h0);
    chk("lit_r6", 6, gpr_flat[6*32 +: 32], 32'h0);
    chk("lit_bad", 0, {31'd0, bad_sel}, 32'd0);
    wr(5'd20, 32'hFFFFFFFF);
    chk("lit_pc_max", 0, pc_q, 32'hFFFFFFFF);
    step(0, 0, 5'd0, 32'd0, 1, 0, 64'd0, 0, 32'd0);
    chk("lit_pc_wrap", 0, pc_q, 32'h0);
    step(0, 1, 5'd20, 32'h100, 1, 0, 64'd0, 0, 32'd0);
    chk("lit_pc_wr_wins", 0, pc_q, 32'h100);
    step(0, 1, 5'd3, 32'h33, 1, 0, 64'd0, 0, 32'd0);
    chk("lit_pc_inc", 0, pc_q, 32'h101);
    chk("lit_r3", 3, gpr_flat[3*32 +: 32], 32'h33);
    step(0, 1, 5'd19, 32'h5, 0, 1, 64'h00000001_80000000, 0, 32'd0);
    chk("lit_zhi", 0, zhi_q, 32'h1);
    chk("lit_zlo", 0, zlo_q, 32'h80000000);
    wr(5'd18, 32'h77);
    chk("lit_zhi_bus", 0, zhi_q, 32'h77);
    wr(5'd16, 32'h1616);
    wr(5'd17, 32'h1717);
    wr(5'd22, 32'h2222);
    chk("lit_hi", 0, hi_q, 32'h1616);
    chk("lit_outport", 0, outport_q, 32'h2222);
    wr(5'd27, 32'hBAD0BAD0);
    chk("lit_bad_set", 0, {31'd0, bad_sel}, 32'd1);
    step(0, 0, 5'd31, 32'h1, 0, 0, 64'd0, 0, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("lit_bad_hold", 0, {31'd0, bad_sel}, 32'd1);
    chk("lit_lo_kept", 0, lo_q, 32'h1717);
    step(1, 1, 5'd1, 32'h11, 1, 0, 64'd0, 0, 32'd0);
    chk("lit_bad_clr", 0, {31'd0, bad_sel}, 32'd0);
    chk("lit_pc_clr", 0, pc_q, 32'h0);
    chk("lit_r1_clr", 1, gpr_flat[1*32 +: 32], 32'h0);
    step(0, 0, 5'd27, 32'h1, 0, 0, 64'd0, 0, 32'd0);
    chk("lit_bad_noen", 0, {31'd0, bad_sel}, 32'd0);
    step(0, 1, 5'd21, 32'h9999, 0, 0, 64'd0, 1, 32'h1234);
    chk("lit_mdr_wins", 0, mdr_q, 32'h1234);
    step(0, 1, 5'd23, 32'hCAFE, 0, 0, 64'd0, 1, 32'h5678);
    chk("lit_mdr", 0, mdr_q, 32'h5678);
    chk("lit_mar", 0, mar_q, 32'hCAFE);
    wr(5'd21, 32'hABCD);
    chk("lit_mdr_bus", 0, mdr_q, 32'hABCD);
    step(0, 1, 5'd15, 32'hF0F0, 1, 1, 64'h12345678_9ABCDEF0, 1, 32'h4321);
    chk("lit_r15", 15, gpr_flat[15*32 +: 32], 32'hF0F0);
    chk("lit_pc_ind", 0, pc_q, 32'h1);
    chk("lit_zlo_ind", 0, zlo_q, 32'h9ABCDEF0);
    wr(5'd0, 32'hA5A5A5A5);
`ifdef REGFILE_R0_ZERO_EN
    chk("lit_r0", 0, gpr_flat[31:0], 32'h0);
`else
    chk("lit_r0", 0, gpr_flat[31:0], 32'hA5A5A5A5);
`endif
    chk("lit_bad_r0", 0, {31'd0, bad_sel}, 32'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_dest_regfile.md
Name: bus_dest_regfile

Overview:
- Destination end of the datapath bus: captures the shared 32-bit bus value into the register selected by a 5-bit destination code.
- Source code map is identical to the bus multiplexer's map, so one code names the same register on both ends of the bus.
- Holds R0–R15, HI, LO, Z (64-bit, high/low), PC, MDR, Out_Port and MAR, and presents their contents back to the bus-source side.
- Provides PC auto-increment, ALU result capture into Z, and memory-data capture into MDR.

Parameters:
- DATA_W, 32, width of bus and every register.
- PC_STEP, 1, increment applied to PC on pc_inc.
- PC_RESET, 0, PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  synchronous, active-high reset.
- bus_in  in  DATA_W  current bus value to be written.
- dest_sel  in  5  destination code (map under Behaviour).
- wr_en  in  1  write strobe; bus_in → register dest_sel this edge.
- pc_inc  in  1  PC ← PC + PC_STEP.
- z_load  in  1  Z ← alu_result.
- alu_result  in  2*DATA_W  ALU output; high half → Zhigh, low half → Zlow.
- mdr_read  in  1  MDR ← mem_data (else MDR is loaded from bus on write).
- mem_data  in  DATA_W  memory read data.
- gpr_flat  out  16*DATA_W  R0..R15 packed, R0 in LSBs.
- hi_q, lo_q, zhi_q, zlo_q, pc_q, mdr_q, outport_q, mar_q  out  DATA_W each  register contents.
- bad_sel  out  1  sticky flag: write attempted with illegal code.

Behaviour:
- Code map: 0–15 = R0–R15; 16 = HI; 17 = LO; 18 = Zhigh; 19 = Zlow; 20 = PC; 21 = MDR; 22 = Out_Port; 23 = MAR; 24–31 illegal.
- Reset: clr=1 at an edge sets every register to 0, except PC = PC_RESET, and sets bad_sel = 0. clr overrides all other inputs that edge, including a write or increment in progress.
- Write: wr_en=1 and legal code → selected register takes bus_in at the edge. Output visible the following cycle (1-cycle latency). No other register changes.
- Illegal write: wr_en=1 and code 24–31 → no register changes; bad_sel set to 1 and held until clr.
- wr_en=0 → dest_sel is ignored; bad_sel is not affected.
- PC priority: bus write to PC (code 20) beats pc_inc the same edge.
  - pc_inc alone → PC + PC_STEP, modulo 2^DATA_W; 0xFFFFFFFF wraps to 0 with PC_STEP=1.
- Z priority: z_load beats a bus write to code 18 or 19 the same edge.
  - z_load writes both halves atomically.
- MDR priority: mdr_read beats a bus write to code 21 the same edge.
- Independence: pc_inc, z_load and mdr_read may coincide with a write to any other register. All of them take effect in that edge.
- Outputs are pure register outputs, with no combinational path from any input.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined: R0 is hardwired to 0. Writes to code 0 are silently discarded (bad_sel is not set), and gpr_flat[DATA_W-1:0] is always 0.
- Undefined: R0 is an ordinary writable register.

Decomposition:
- Shared package regfile_pkg:
  - destination code constants: DEST_R0..DEST_R15, DEST_HI, DEST_LO, DEST_ZHI, DEST_ZLO, DEST_PC, DEST_MDR, DEST_OUTPORT, DEST_MAR, DEST_LAST_LEGAL = 23.
  - DATA_W default.
  - The bus multiplexer uses the same constants.
- One sub-module, bus_reg: a DATA_W register with clr, load enable and a reset-value parameter. Every plain register in the block is an instance of bus_reg.
- PC, Z and MDR wrap bus_reg with small priority muxes.

Test Plan:
1. Reset, then wr_en=1, dest_sel=5, bus_in=0xDEADBEEF → next cycle R5 = 0xDEADBEEF; all other GPRs 0; bad_sel=0.
2. pc_q=0xFFFFFFFF, pc_inc=1 → pc_q=0. Then pc_inc=1 together with wr_en=1, dest_sel=20, bus_in=0x100 → pc_q=0x100.
3. z_load=1, alu_result=0x00000001_80000000, with wr_en=1, dest_sel=19, bus_in=0x5 → zhi_q=1, zlo_q=0x80000000.
4. wr_en=1, dest_sel=27 → no register changes; bad_sel=1 and remains 1 over 10 idle cycles; clr → bad_sel=0.
5. mdr_read=1, mem_data=0x1234, with wr_en=1, dest_sel=21, bus_in=0x9999 → mdr_q=0x1234. Same edge, wr_en with dest_sel=23 instead → MAR and MDR both update.
6. wr_en=1, dest_sel=0, bus_in=0xA5A5A5A5 → R0 = 0xA5A5A5A5 without REGFILE_R0_ZERO_EN; R0 = 0 and bad_sel = 0 with it.
